lifo_arb: RTL and testbench

LIFO_ARB -- requirements
Module: lifo_arb

---
 rtl/lifo_arb.sv | 127 ++++++++++++
 tb/tb_lifo_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arb.sv
// lifo_arb: two-client arbiter in front of a single shared LIFO.
// Each client may request a push, a pop, or both. One operation is issued at
// most every three cycles, and every output is driven from a register.
//   push: IDLE (grant) -> PUSH (wrreq + ack) -> SETTLE -> IDLE
//   pop : IDLE (grant) -> POP (rdreq + ack) -> POP_WAIT -> IDLE (valid + data)
// SETTLE and POP_WAIT give the LIFO flags time to update before the next grant.
module lifo_arb #(
    parameter int DWIDTH = 8
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [1:0]          push_req_i,
    input  logic [2*DWIDTH-1:0] push_data_i,
    output logic [1:0]          push_ack_o,
    input  logic [1:0]          pop_req_i,
    output logic [1:0]          pop_ack_o,
    output logic [1:0]          pop_valid_o,
    output logic [DWIDTH-1:0]   pop_data_o,
    output logic [DWIDTH-1:0]   lifo_data_o,
    output logic                lifo_wrreq_o,
    output logic                lifo_rdreq_o,
    input  logic [DWIDTH-1:0]   lifo_q_i,
    input  logic                lifo_empty_i,
    input  logic                lifo_full_i
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PUSH     = 3'd1;
    localparam logic [2:0] ST_POP      = 3'd2;
    localparam logic [2:0] ST_POP_WAIT = 3'd3;
    localparam logic [2:0] ST_SETTLE   = 3'd4;

    logic [2:0]        state;
    logic              rr_prio;
    logic              op_client;

    logic [1:0]        push_elig;
    logic [1:0]        pop_elig;
    logic [1:0]        client_elig;
    logic              grant_valid;
    logic              grant_sel;
    logic              grant_is_pop;
    logic [1:0]        grant_onehot;
    logic [1:0]        op_onehot;
    logic [DWIDTH-1:0] grant_data;

    // Pick a winner in IDLE: the favoured client first, and pop beats push within a client
    always_comb begin
        push_elig    = push_req_i & {2{~lifo_full_i}};
        pop_elig     = pop_req_i & {2{~lifo_empty_i}};
        client_elig  = push_elig | pop_elig;
        grant_valid  = (state == ST_IDLE) && (client_elig != 2'b00);
        grant_sel    = rr_prio;
        if (!client_elig[rr_prio]) begin
            grant_sel = ~rr_prio;
        end
        grant_is_pop = pop_elig[grant_sel];
        grant_onehot = grant_sel ? 2'b10 : 2'b01;
        op_onehot    = op_client ? 2'b10 : 2'b01;
        grant_data   = grant_sel ? push_data_i[DWIDTH +: DWIDTH] : push_data_i[0 +: DWIDTH];
    end

    // Sequencer: state, round-robin pointer and the owner of the operation in flight
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= ST_IDLE;
            rr_prio   <= 1'b0;
            op_client <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        rr_prio   <= ~grant_sel;
                        op_client <= grant_sel;
                        state     <= grant_is_pop ? ST_POP : ST_PUSH;
                    end
                end
                ST_PUSH:     state <= ST_SETTLE;
                ST_POP:      state <= ST_POP_WAIT;
                ST_POP_WAIT: state <= ST_IDLE;
                ST_SETTLE:   state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Registered LIFO strobes and client acks; each strobe lives for exactly one cycle
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lifo_wrreq_o <= 1'b0;
            lifo_rdreq_o <= 1'b0;
            lifo_data_o  <= '0;
            push_ack_o   <= 2'b00;
            pop_ack_o    <= 2'b00;
        end else begin
            lifo_wrreq_o <= 1'b0;
            lifo_rdreq_o <= 1'b0;
            push_ack_o   <= 2'b00;
            pop_ack_o    <= 2'b00;
            if (grant_valid) begin
                if (grant_is_pop) begin
                    lifo_rdreq_o <= 1'b1;
                    pop_ack_o    <= grant_onehot;
                end else begin
                    lifo_wrreq_o <= 1'b1;
                    lifo_data_o  <= grant_data;
                    push_ack_o   <= grant_onehot;
                end
            end
        end
    end

    // Capture the LIFO read data one cycle after rdreq and flag it to the requesting client
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pop_data_o  <= '0;
            pop_valid_o <= 2'b00;
        end else begin
            pop_valid_o <= 2'b00;
            if (state == ST_POP_WAIT) begin
                pop_data_o  <= lifo_q_i;
                pop_valid_o <= op_onehot;
            end
        end
    end

endmodule

// File: tb/tb_lifo_arb.sv
// tb_lifo_arb: drives lifo_arb with directed and random client traffic against
// a small behavioural LIFO, and compares every output every cycle with a
// transaction-level prediction (stack contents plus a "busy until" cycle).
module tb_lifo_arb;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int NCYC  = 4000;

    logic          clk;
    logic          srst;
    logic [1:0]    push_req;
    logic [DW-1:0] cdata [2];
    logic [2*DW-1:0] push_data;
    logic [1:0]    push_ack;
    logic [1:0]    pop_req;
    logic [1:0]    pop_ack;
    logic [1:0]    pop_valid;
    logic [DW-1:0] pop_data;
    logic [DW-1:0] lifo_data;
    logic          lifo_wrreq;
    logic          lifo_rdreq;
    logic [DW-1:0] lifo_q;
    logic          lifo_empty;
    logic          lifo_full;

    int num_checks = 0;
    int num_errors = 0;
    int cyc        = 0;

    // Environment LIFO
    logic [DW-1:0] env_mem [DEPTH];
    int            env_cnt = 0;

    // Prediction state
    logic [1:0]    exp_pack  [NCYC];
    logic [1:0]    exp_qack  [NCYC];
    logic [1:0]    exp_valid [NCYC];
    logic          exp_wr    [NCYC];
    logic          exp_rd    [NCYC];
    logic          exp_rst   [NCYC];
    logic [DW-1:0] exp_wdata [NCYC];
    logic [DW-1:0] exp_vdata [NCYC];
    logic [DW-1:0] m_stack   [DEPTH];
    int            m_cnt   = 0;
    int            m_rr    = 0;
    int            free_at = 0;
    logic [DW-1:0] exp_pop_data_cur = '0;

    assign push_data = {cdata[1], cdata[0]};
    assign lifo_full  = (env_cnt == DEPTH);
    assign lifo_empty = (env_cnt == 0);

    lifo_arb #(.DWIDTH(DW)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .push_req_i   (push_req),
        .push_data_i  (push_data),
        .push_ack_o   (push_ack),
        .pop_req_i    (pop_req),
        .pop_ack_o    (pop_ack),
        .pop_valid_o  (pop_valid),
        .pop_data_o   (pop_data),
        .lifo_data_o  (lifo_data),
        .lifo_wrreq_o (lifo_wrreq),
        .lifo_rdreq_o (lifo_rdreq),
        .lifo_q_i     (lifo_q),
        .lifo_empty_i (lifo_empty),
        .lifo_full_i  (lifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial lifo_q = '0;

    // Behavioural LIFO with registered read data; it is not reset by the arbiter's reset
    always @(posedge clk) begin
        if (lifo_wrreq) begin
            if (env_cnt < DEPTH) begin
                env_mem[env_cnt] <= lifo_data;
                env_cnt <= env_cnt + 1;
            end
        end else if (lifo_rdreq) begin
            if (env_cnt > 0) begin
                lifo_q  <= env_mem[env_cnt-1];
                env_cnt <= env_cnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    // Decide what the arbiter must do with the inputs present during cycle c
    task automatic modelCycle(input int c);
        logic [1:0] pe;
        logic [1:0] qe;
        logic [1:0] anyk;
        int g;
        if (srst) begin
            for (int i = c + 1; i <= c + 3; i++) begin
                exp_pack[i]  = 2'b00;
                exp_qack[i]  = 2'b00;
                exp_valid[i] = 2'b00;
                exp_wr[i]    = 1'b0;
                exp_rd[i]    = 1'b0;
            end
            exp_rst[c+1] = 1'b1;
            m_rr    = 0;
            free_at = c + 1;
        end else if (c >= free_at) begin
            pe   = push_req & {2{m_cnt != DEPTH}};
            qe   = pop_req & {2{m_cnt != 0}};
            anyk = pe | qe;
            g    = -1;
            if (anyk[m_rr]) g = m_rr;
            else if (anyk[1-m_rr]) g = 1 - m_rr;
            if (g >= 0) begin
                m_rr    = 1 - g;
                free_at = c + 3;
                if (qe[g]) begin
                    exp_rd[c+1]    = 1'b1;
                    exp_qack[c+1]  = 2'(1 << g);
                    exp_valid[c+3] = 2'(1 << g);
                    exp_vdata[c+3] = m_stack[m_cnt-1];
                    m_cnt--;
                end else begin
                    exp_wr[c+1]    = 1'b1;
                    exp_pack[c+1]  = 2'(1 << g);
                    exp_wdata[c+1] = cdata[g];
                    m_stack[m_cnt] = cdata[g];
                    m_cnt++;
                end
            end
        end
    endtask

    // Compare all DUT outputs of cycle t against the prediction
    task automatic checkCycle(input int t);
        if (exp_rst[t]) begin
            exp_pop_data_cur = '0;
            checkOutput("lifo_data_rst", 32'(lifo_data), 32'(0));
        end
        if (exp_valid[t] != 2'b00) exp_pop_data_cur = exp_vdata[t];
        checkOutput("lifo_wrreq", 32'(lifo_wrreq), 32'(exp_wr[t]));
        checkOutput("lifo_rdreq", 32'(lifo_rdreq), 32'(exp_rd[t]));
        checkOutput("push_ack",   32'(push_ack),   32'(exp_pack[t]));
        checkOutput("pop_ack",    32'(pop_ack),    32'(exp_qack[t]));
        checkOutput("pop_valid",  32'(pop_valid),  32'(exp_valid[t]));
        checkOutput("pop_data",   32'(pop_data),   32'(exp_pop_data_cur));
        if (exp_wr[t]) checkOutput("lifo_data", 32'(lifo_data), 32'(exp_wdata[t]));
    endtask

    // One clock: predict, advance, check, and let clients drop acknowledged requests
    task automatic applyStimulus();
        modelCycle(cyc);
        @(posedge clk);
        #1;
        cyc++;
        checkCycle(cyc);
        push_req = push_req & ~push_ack;
        pop_req  = pop_req & ~pop_ack;
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_pack[i] = '0; exp_qack[i] = '0; exp_valid[i] = '0;
            exp_wr[i] = 1'b0; exp_rd[i] = 1'b0; exp_rst[i] = 1'b0;
            exp_wdata[i] = '0; exp_vdata[i] = '0;
        end
        srst = 1'b1; push_req = 2'b00; pop_req = 2'b00;
        cdata[0] = '0; cdata[1] = '0;

        // Reset state
        repeat (2) applyStimulus();
        srst = 1'b0;
        applyStimulus();

        // Single push of 0xA5 by client 0
        push_req[0] = 1'b1; cdata[0] = 8'hA5;
        repeat (4) applyStimulus();

        // Client 1 pushes 0x3C then pops it back
        push_req[1] = 1'b1; cdata[1] = 8'h3C;
        repeat (4) applyStimulus();
        pop_req[1] = 1'b1;
        repeat (4) applyStimulus();

        // Contention after reset: both clients push continuously
        srst = 1'b1;
        applyStimulus();
        srst = 1'b0;
        repeat (12) begin
            push_req = 2'b11;
            cdata[0] = 8'($urandom); cdata[1] = 8'($urandom);
            applyStimulus();
        end

        // Fill to full with client 0, then client 1 pops while client 0 keeps pushing
        repeat (30) begin push_req[0] = 1'b1; applyStimulus(); end
        pop_req[1] = 1'b1;
        repeat (8) begin push_req[0] = 1'b1; applyStimulus(); end
        push_req = 2'b00; pop_req = 2'b00;
        repeat (3) applyStimulus();

        // Drain to empty, then keep popping on empty
        repeat (40) begin pop_req[1] = 1'b1; applyStimulus(); end
        pop_req = 2'b00;

        // Empty: client 0 has push and pop pending; push must go first
        push_req[0] = 1'b1; pop_req[0] = 1'b1; cdata[0] = 8'h5A;
        repeat (8) applyStimulus();

        // Reset while the pop is in POP_WAIT
        push_req[0] = 1'b1; cdata[0] = 8'h77;
        repeat (4) applyStimulus();
        pop_req[0] = 1'b1;
        repeat (2) applyStimulus();
        srst = 1'b1;
        applyStimulus();
        srst = 1'b0;
        push_req[1] = 1'b1; cdata[1] = 8'h42;
        repeat (5) applyStimulus();

        // Random traffic with occasional withdrawals and resets
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!push_req[k] && $urandom_range(0, 3) == 0) begin
                    push_req[k] = 1'b1;
                    cdata[k] = 8'($urandom);
                end else if (push_req[k] && $urandom_range(0, 39) == 0) begin
                    push_req[k] = 1'b0;
                end
                if (!pop_req[k] && $urandom_range(0, 3) == 0) pop_req[k] = 1'b1;
                else if (pop_req[k] && $urandom_range(0, 39) == 0) pop_req[k] = 1'b0;
            end
            srst = ($urandom_range(0, 99) == 0);
            applyStimulus();
        end
        srst = 1'b0; push_req = 2'b00; pop_req = 2'b00;
        repeat (4) applyStimulus();

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
